// File: rtl/neural_soc_button_if.sv
// rtl/neural_soc_button_if.sv - Avalon-MM slave register bus for the button input port
// Master drives address/strobes/write data; slave returns registered read data.
interface neural_soc_button_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/neural_soc_button.sv
// rtl/neural_soc_button.sv - synchronized button/switch input port with sticky edge capture and irq
// DATA / IRQMASK / reserved / EDGECAPTURE (write-1-to-clear) on a 4-word window.
module neural_soc_button #(
    parameter int WIDTH       = 4,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    neural_soc_button_if.slave     bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync;
    logic [WIDTH-1:0]                  sync_d_q;
    logic [WIDTH-1:0]                  edge_det;
    logic [WIDTH-1:0]                  irqmask_q, irqmask_d;
    logic [WIDTH-1:0]                  edgecap_q, edgecap_d;
    logic [WIDTH-1:0]                  clr_mask;
    logic [31:0]                       readdata_q, readdata_d;
    logic                              wr_en;

    assign sync  = sync_q[SYNC_STAGES-1];
    assign wr_en = bus.chipselect && !bus.write_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            sync_d_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], in_port};
            sync_d_q <= sync;
        end
    end

    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = sync & ~sync_d_q;
            1:       edge_det = ~sync & sync_d_q;
            default: edge_det = sync ^ sync_d_q;
        endcase
    end

    // A new edge is ORed in after the clear, so a same-cycle set beats the clear.
    always_comb begin
        clr_mask  = '0;
        irqmask_d = irqmask_q;
        if (wr_en && bus.address == ADDR_IRQMASK)
            irqmask_d = bus.writedata[WIDTH-1:0];
        if (wr_en && bus.address == ADDR_EDGECAP)
            clr_mask = bus.writedata[WIDTH-1:0];
        edgecap_d = (edgecap_q & ~clr_mask) | edge_det;
    end

    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = sync;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = |(edgecap_q & irqmask_q);

    generate
        if (WIDTH < 32) begin : g_unused_wd
            logic unused_writedata;
            assign unused_writedata = ^bus.writedata[31:WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_neural_soc_button.sv
// tb/tb_neural_soc_button.sv - directed self-checking bench for neural_soc_button
// Rising-edge instance dut0 and falling-edge instance dut1 share clock and reset.
module tb_neural_soc_button;

    logic       clk;
    logic       reset_n;
    logic [3:0] in_port0;
    logic [3:0] in_port1;
    logic       irq0;
    logic       irq1;
    int         n_vec;
    int         n_err;
    logic [31:0] rd;

    neural_soc_button_if bus0 ();
    neural_soc_button_if bus1 ();

    neural_soc_button #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0.slave),
        .in_port (in_port0),
        .irq     (irq0)
    );

    neural_soc_button #(.WIDTH(4), .EDGE_TYPE(1), .SYNC_STAGES(2)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1.slave),
        .in_port (in_port1),
        .irq     (irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int sel, input logic [1:0] a, input logic [31:0] d, input logic cs);
        if (sel == 0) begin
            bus0.address = a; bus0.writedata = d; bus0.chipselect = cs; bus0.write_n = 1'b0;
        end else begin
            bus1.address = a; bus1.writedata = d; bus1.chipselect = cs; bus1.write_n = 1'b0;
        end
        tick();
        bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
        bus1.chipselect = 1'b0; bus1.write_n = 1'b1;
    endtask

    task automatic rdreg(input int sel, input logic [1:0] a, output logic [31:0] d);
        if (sel == 0) begin
            bus0.address = a; bus0.chipselect = 1'b1; bus0.write_n = 1'b1;
        end else begin
            bus1.address = a; bus1.chipselect = 1'b1; bus1.write_n = 1'b1;
        end
        tick();
        d = (sel == 0) ? bus0.readdata : bus1.readdata;
        bus0.chipselect = 1'b0;
        bus1.chipselect = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        in_port0 = 4'h0;
        in_port1 = 4'h0;
        bus0.address = 2'd0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
        bus1.address = 2'd0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.writedata = '0;

        // reset state
        ticks(3);
        check("reset_readdata", bus0.readdata, 32'h0);
        check("reset_irq", {31'b0, irq0}, 32'h0);
        reset_n = 1'b1;
        ticks(2);
        for (int a = 0; a < 4; a++) begin
            rdreg(0, a[1:0], rd);
            check($sformatf("post_reset_addr%0d", a), rd, 32'h0);
        end

        // rising edge with irq
        wr(0, 2'd1, 32'h5, 1'b1);
        rdreg(0, 2'd1, rd);
        check("irqmask_5", rd, 32'h5);
        in_port0 = 4'h1;
        ticks(2);
        check("irq_before_e2", {31'b0, irq0}, 32'h0);
        tick();
        check("irq_after_e2", {31'b0, irq0}, 32'h1);
        rdreg(0, 2'd3, rd);
        check("edgecap_rise", rd, 32'h1);
        rdreg(0, 2'd0, rd);
        check("data_rise", rd, 32'h1);
        rdreg(0, 2'd3, rd);
        check("read_no_clear", rd, 32'h1);
        wr(0, 2'd3, 32'h1, 1'b1);
        check("irq_after_clear", {31'b0, irq0}, 32'h0);
        rdreg(0, 2'd3, rd);
        check("edgecap_cleared", rd, 32'h0);

        // masked edge on bit 3, then unmask
        wr(0, 2'd1, 32'h0, 1'b1);
        in_port0 = 4'h9;
        ticks(3);
        in_port0 = 4'h1;
        ticks(4);
        check("irq_masked", {31'b0, irq0}, 32'h0);
        rdreg(0, 2'd3, rd);
        check("edgecap_masked", rd, 32'h8);
        wr(0, 2'd1, 32'h8, 1'b1);
        check("irq_unmasked", {31'b0, irq0}, 32'h1);
        wr(0, 2'd3, 32'h8, 1'b1);
        check("irq_bit3_cleared", {31'b0, irq0}, 32'h0);

        // simultaneous set and clear on bit 0
        wr(0, 2'd1, 32'h1, 1'b1);
        in_port0 = 4'h0;
        ticks(4);
        in_port0 = 4'h1;
        ticks(2);
        wr(0, 2'd3, 32'h1, 1'b1);
        check("irq_set_wins", {31'b0, irq0}, 32'h1);
        rdreg(0, 2'd3, rd);
        check("edgecap_set_wins", rd, 32'h1);
        wr(0, 2'd3, 32'h1, 1'b1);
        check("irq_late_clear", {31'b0, irq0}, 32'h0);

        // write decode: ignored writes
        wr(0, 2'd1, 32'hF, 1'b0);
        wr(0, 2'd0, 32'hF, 1'b1);
        wr(0, 2'd2, 32'hF, 1'b1);
        rdreg(0, 2'd1, rd);
        check("mask_unchanged", rd, 32'h1);
        rdreg(0, 2'd2, rd);
        check("reserved_zero", rd, 32'h0);
        rdreg(0, 2'd3, rd);
        check("edgecap_unchanged", rd, 32'h0);
        rdreg(0, 2'd0, rd);
        check("data_unchanged", rd, 32'h1);

        // falling-edge instance
        in_port1 = 4'h4;
        ticks(4);
        rdreg(1, 2'd3, rd);
        check("fall_ignores_rise", rd, 32'h0);
        in_port1 = 4'h0;
        ticks(3);
        rdreg(1, 2'd3, rd);
        check("fall_captured", rd, 32'h4);

        // async reset mid-operation
        wr(0, 2'd1, 32'hF, 1'b1);
        in_port0 = 4'h0;
        ticks(4);
        in_port0 = 4'hF;
        ticks(4);
        check("irq_all", {31'b0, irq0}, 32'h1);
        rdreg(0, 2'd3, rd);
        check("edgecap_all", rd, 32'hF);
        rdreg(0, 2'd1, rd);
        #2;
        in_port0 = 4'h0;
        reset_n = 1'b0;
        #1;
        check("async_irq", {31'b0, irq0}, 32'h0);
        check("async_readdata", bus0.readdata, 32'h0);
        ticks(2);
        reset_n = 1'b1;
        ticks(3);
        rdreg(0, 2'd1, rd);
        check("mask_after_reset", rd, 32'h0);
        rdreg(0, 2'd3, rd);
        check("edgecap_after_reset", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/neural_soc_button.md
# neural_soc_button

Memory-mapped input port with edge capture and interrupt generation, the read-side counterpart of the LED output port on the same Avalon-MM slave bus of the neural SoC. It synchronizes `WIDTH` asynchronous board inputs (push-buttons / switches), latches selected edges into a sticky capture register, and raises a level interrupt to the Nios processor when an unmasked captured edge is pending. Software reads live pin state, reads and clears captured edges, and programs the interrupt mask through a 4-word register window.

## Interface

**Parameters**

- `WIDTH`, default 4: number of input pins, 1..32.
- `EDGE_TYPE`, default 0: edge detected. 0 = rising, 1 = falling, 2 = any.
- `SYNC_STAGES`, default 2: synchronizer flops per pin, 2..4.

**Ports**

- `clk` input 1: single system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `address` input 2: word address within the register window.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe. A write occurs only when `chipselect` is high and `write_n` is low.
- `writedata` input 32: write data. Only bits `[WIDTH-1:0]` are used.
- `in_port` input `WIDTH`: asynchronous external pins.
- `readdata` output 32: registered read data. Bits above `WIDTH-1` are always 0.
- `irq` output 1: level interrupt, active high.

## Operation

**Register map**

- Address 0, DATA, read-only: synchronized pin state (last synchronizer stage). Writes are ignored.
- Address 1, IRQMASK, read/write: per-bit interrupt enable. A write loads `writedata[WIDTH-1:0]`.
- Address 2: reserved. Reads return 0; writes are ignored.
- Address 3, EDGECAPTURE, read / write-1-to-clear: a write clears each bit whose `writedata` bit is 1. Bits written as 0 are unchanged.

**Input path**

- `SYNC_STAGES`-deep flop chain per pin, producing `sync`.
- One further delay register, `sync_d`.

**Edge detection**

- Rising edge: `sync & ~sync_d`.
- Falling edge: `~sync & sync_d`.
- Any edge: `sync ^ sync_d`.

**Edge capture**

- A bit sets on a detected edge and stays set until software clears it.
- If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- Each bit is independent.

**Interrupt**

- `irq = |(EDGECAPTURE & IRQMASK)`, decoded combinationally from registers only, so it is glitch-free.
- Changing IRQMASK affects `irq` in the cycle after the write edge.

**Read path**

- `readdata` is loaded on every clock from a mux on `address`.
- Reads have no side effects. A read does not clear EDGECAPTURE.

**Reset values** (all state is cleared asynchronously by `reset_n` low)

- Synchronizer, `sync_d`, IRQMASK, EDGECAPTURE: 0.
- `readdata`: 0.
- `irq`: 0.

**Reset-related behaviour**

- A pin held high through reset is seen as a rising edge after release. The edge is captured `SYNC_STAGES` cycles after the first post-reset edge. This is intended behaviour.
- Asserting reset mid-operation discards pending edges and the mask immediately, and `irq` deasserts asynchronously.

## Timing

- **Pin to DATA:** a pin change sampled at edge E0 appears in DATA after edge E(`SYNC_STAGES`-1).
- **Pin to capture:** with the default `SYNC_STAGES` = 2, EDGECAPTURE sets and `irq` asserts (if masked in) after edge E2. That is a latency of `SYNC_STAGES` cycles.
- **Read latency:** 1 cycle. `readdata` reflects the `address` presented at edge N, valid after edge N.
- **Write:** takes effect at the write edge. A clear of EDGECAPTURE is visible on a read addressed in the next cycle. `irq` deasserts after that same edge unless a new edge sets the bit.
- **Pulse width:** pulses shorter than one clock period may be missed. Any level held for at least 2 clocks is guaranteed detected.
- **Back-to-back edges:** a second edge before a clear is absorbed, so capture is sticky, not counting.

## Test plan

- **Reset:** `reset_n` = 0 with `in_port` = 0 → `readdata`, `irq`, IRQMASK and EDGECAPTURE all 0. Release reset, read addresses 0..3 → all return 0x00000000.
- **Rising edge with IRQ:** write IRQMASK = 0x5, drive `in_port` 0x0 → 0x1 at E0 →
  - EDGECAPTURE = 0x1 and `irq` = 1 after E2.
  - A read of address 0 returns 0x00000001.
  - Writing 0x1 to address 3 drops `irq` the next cycle, and EDGECAPTURE reads 0x0.
- **Masked edge:** IRQMASK = 0x0, pulse `in_port` bit 3 high for 3 cycles → EDGECAPTURE = 0x8 and `irq` stays 0. Then write IRQMASK = 0x8 → `irq` = 1 one cycle later.
- **Simultaneous set and clear:** time a bit-0 rising edge detection to coincide with a write of 0x1 to address 3 → EDGECAPTURE bit 0 remains 1 and `irq` stays asserted.
- **Edge type and write decode:**
  - `EDGE_TYPE` = 1: a 1→0 transition on bit 2 → EDGECAPTURE = 0x4. A 0→1 transition leaves it 0.
  - Writes with `chipselect` = 0, or to address 0 or 2 → no register changes.
- **Async reset mid-operation:** EDGECAPTURE = 0xF and `irq` = 1, then pulse `reset_n` low between clock edges → `irq` and all registers go to 0 immediately, without waiting for a clock edge.
